// File: rtl/spi_8to1_transmit.sv
// SPI data-layer byte transmitter: a one-entry holding buffer feeds an 8-bit shift register,
// which shifts out one bit per im_work_pluse strobe. Bit order matches the 1-to-8 receiver.
module spi_8to1_transmit #(
  parameter logic IDLE_LEVEL = 1'b0,
  parameter bit   MSB_FIRST  = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       im_work_en,
  input  logic       im_work_pluse,
  input  logic [7:0] im_byte,
  input  logic       im_byte_valid,
  output logic       om_byte_ready,
  output logic       om_data,
  output logic       om_busy,
  output logic       om_byte_done,
  output logic       om_underrun
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;

  logic [7:0] r_shift;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_buf;
  logic       r_buf_full;
  logic       r_data;
  logic       r_done;
  logic       r_underrun;

  logic       w_wr;
  logic       w_last;
  logic       w_slot;
  logic       w_load_buf;
  logic       w_load_byp;
  logic       w_load;
  logic       w_mid;
  logic       w_underrun;
  logic [7:0] w_load_byte;
  logic [7:0] w_shift_adv;
  logic       w_next_bit;

  function automatic logic first_bit(input logic [7:0] b);
    return MSB_FIRST ? b[7] : b[0];
  endfunction

  // Handshake and load-slot decode. A load slot is any edge where the shift register
  // is empty or is consuming its last bit; the buffer has priority over the bypass path.
  assign w_wr        = im_byte_valid && !r_buf_full;
  assign w_last      = (r_state == S_SHIFT) && im_work_pluse && (r_bit_cnt == 3'd7);
  assign w_slot      = im_work_en && ((r_state == S_IDLE) || w_last);
  assign w_load_buf  = w_slot && r_buf_full;
  assign w_load_byp  = w_slot && !r_buf_full && w_wr;
  assign w_load      = w_load_buf || w_load_byp;
  assign w_load_byte = r_buf_full ? r_buf : im_byte;
  assign w_mid       = im_work_en && (r_state == S_SHIFT) && im_work_pluse
                       && (r_bit_cnt != 3'd7);
  assign w_underrun  = im_work_en && (r_state == S_IDLE) && im_work_pluse;

  assign w_shift_adv = MSB_FIRST ? {r_shift[6:0], 1'b0} : {1'b0, r_shift[7:1]};
  assign w_next_bit  = MSB_FIRST ? r_shift[6] : r_shift[1];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of block evaluation order.
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; dropping im_work_en aborts to IDLE ahead of everything else.
  always_comb begin
    // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
    w_state_nxt = r_state;
    if (!im_work_en) begin
      w_state_nxt = S_IDLE;
    end else if (w_slot) begin
      w_state_nxt = w_load ? S_SHIFT : S_IDLE;
    end
  end

  // Holding buffer: retained across aborts; writes land here unless bypassed straight
  // into the shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf      <= 8'h00;
      r_buf_full <= 1'b0;
    end else if (w_load_buf) begin
      r_buf_full <= 1'b0;
    end else if (w_wr && !w_load_byp) begin
      r_buf      <= im_byte;
      r_buf_full <= 1'b1;
    end
  end

  // Shift register, bit counter and registered serial bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= 8'h00;
      r_bit_cnt <= 3'd0;
      r_data    <= IDLE_LEVEL;
    end else if (!im_work_en) begin
      r_shift   <= 8'h00;
      r_bit_cnt <= 3'd0;
      r_data    <= IDLE_LEVEL;
    end else if (w_load) begin
      r_shift   <= w_load_byte;
      r_bit_cnt <= 3'd0;
      r_data    <= first_bit(w_load_byte);
    end else if (w_slot) begin
      r_shift   <= 8'h00;
      r_bit_cnt <= 3'd0;
      r_data    <= IDLE_LEVEL;
    end else if (w_mid) begin
      r_shift   <= w_shift_adv;
      r_bit_cnt <= r_bit_cnt + 3'd1;
      r_data    <= w_next_bit;
    end
  end

  // Status pulses, each one cycle after the strobe that caused it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_done     <= im_work_en && w_last;
      r_underrun <= w_underrun;
    end
  end

  // Output logic.
  always_comb begin
    om_byte_ready = !r_buf_full;
    om_busy       = (r_state == S_SHIFT);
    om_data       = r_data;
    om_byte_done  = r_done;
    om_underrun   = r_underrun;
  end

endmodule

// File: tb/tb_spi_8to1_transmit.sv
// Self-checking bench for spi_8to1_transmit: an LSB-first instance and an MSB-first instance
// (idle level 1) share all inputs and are checked against bit-order rules and a loopback receiver model.
module tb_spi_8to1_transmit;

  localparam logic IDLE_L = 1'b0;
  localparam logic IDLE_M = 1'b1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       im_work_en;
  logic       im_work_pluse;
  logic [7:0] im_byte;
  logic       im_byte_valid;

  logic ready_l, data_l, busy_l, done_l, under_l;
  logic ready_m, data_m, busy_m, done_m, under_m;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  spi_8to1_transmit #(.IDLE_LEVEL(IDLE_L), .MSB_FIRST(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .im_work_en(im_work_en), .im_work_pluse(im_work_pluse),
    .im_byte(im_byte), .im_byte_valid(im_byte_valid), .om_byte_ready(ready_l),
    .om_data(data_l), .om_busy(busy_l), .om_byte_done(done_l), .om_underrun(under_l)
  );

  spi_8to1_transmit #(.IDLE_LEVEL(IDLE_M), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk(clk), .rst_n(rst_n), .im_work_en(im_work_en), .im_work_pluse(im_work_pluse),
    .im_byte(im_byte), .im_byte_valid(im_byte_valid), .om_byte_ready(ready_m),
    .om_data(data_m), .om_busy(busy_m), .om_byte_done(done_m), .om_underrun(under_m)
  );

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge (inputs change and outputs are sampled here).
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_byte(input logic [7:0] b);
    int t = 0;
    while (!ready_l && t < 100) begin
      idle(1);
      t++;
    end
    check1("ready_wait", ready_l, 1'b1);
    im_byte       = b;
    im_byte_valid = 1'b1;
    idle(1);
    im_byte_valid = 1'b0;
  endtask

  // One strobe cycle; the serial bits are what the peer samples during the strobe.
  task automatic strobe(output logic dl, output logic dm);
    im_work_pluse = 1'b1;
    dl = data_l;
    dm = data_m;
    idle(1);
    im_work_pluse = 1'b0;
  endtask

  // Shift a byte already loaded in the shift register out to idle, with nothing queued behind it.
  task automatic shift_check(input logic [7:0] b, input int gap);
    logic dl, dm;
    for (int i = 0; i < 8; i++) begin
      idle(gap);
      strobe(dl, dm);
      check1("bit_lsb", dl, b[i]);
      check1("bit_msb", dm, b[7-i]);
      check1("done_lsb", done_l, logic'(i == 7));
      check1("done_msb", done_m, logic'(i == 7));
    end
    check1("end_busy", busy_l, 1'b0);
    check1("end_idle_lsb", data_l, IDLE_L);
    check1("end_idle_msb", data_m, IDLE_M);
    idle(1);
    check1("done_clear", done_l, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    write_byte(b);
    check1("load_busy", busy_l, 1'b1);
    check1("load_first_lsb", data_l, b[0]);
    check1("load_first_msb", data_m, b[7]);
    shift_check(b, gap);
  endtask

  initial begin
    logic       dl, dm;
    logic [7:0] a, c, exp_b, rx_l, rx_m;
    logic [7:0] tx[$];
    logic [7:0] exp_q[$];
    int         n_done, nbits, gapc, cyc;
    logic       pl;

    rst_n = 1'b0; im_work_en = 1'b0; im_work_pluse = 1'b0;
    im_byte = 8'h00; im_byte_valid = 1'b0;
    #12;
    check1("rst_ready", ready_l, 1'b1);
    check1("rst_busy", busy_l, 1'b0);
    check1("rst_data_lsb", data_l, IDLE_L);
    check1("rst_data_msb", data_m, IDLE_M);
    check1("rst_done", done_l, 1'b0);
    check1("rst_under", under_l, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    im_work_en = 1'b1;
    idle(1);

    // Single byte.
    send_byte(8'hA5, 3);

    // Back-to-back: second byte waits in the buffer, then follows with no idle strobe.
    a = 8'h3C;
    c = 8'hC3;
    write_byte(a);
    write_byte(c);
    check1("b2b_ready_full", ready_l, 1'b0);
    for (int i = 0; i < 16; i++) begin
      idle(3);
      strobe(dl, dm);
      check1("b2b_lsb", dl, (i < 8) ? a[i] : c[i-8]);
      check1("b2b_msb", dm, (i < 8) ? a[7-i] : c[15-i]);
      check1("b2b_done", done_l, logic'(i == 7 || i == 15));
      check1("b2b_ready", ready_l, logic'(i >= 7));
      check1("b2b_busy", busy_l, logic'(i != 15));
    end
    idle(1);

    // Underrun: strobes with nothing to send.
    for (int k = 0; k < 2; k++) begin
      idle(2);
      strobe(dl, dm);
      check1("under_pulse_lsb", under_l, 1'b1);
      check1("under_pulse_msb", under_m, 1'b1);
      check1("under_data_lsb", dl, IDLE_L);
      check1("under_data_msb", dm, IDLE_M);
      check1("under_no_done", done_l, 1'b0);
      idle(1);
      check1("under_clear", under_l, 1'b0);
    end
    send_byte(8'h01, 3);

    // Abort mid-byte with a byte queued in the buffer.
    write_byte(8'hFF);
    write_byte(8'h55);
    for (int i = 0; i < 3; i++) begin
      idle(3);
      strobe(dl, dm);
      check1("abort_pre_lsb", dl, 1'b1);
      check1("abort_pre_msb", dm, 1'b1);
    end
    im_work_en = 1'b0;
    idle(1);
    check1("abort_data_lsb", data_l, IDLE_L);
    check1("abort_data_msb", data_m, IDLE_M);
    check1("abort_busy", busy_l, 1'b0);
    check1("abort_buf_kept", ready_l, 1'b0);
    im_work_pluse = 1'b1;
    idle(1);
    im_work_pluse = 1'b0;
    check1("abort_no_done", done_l, 1'b0);
    check1("abort_no_under", under_l, 1'b0);
    check1("abort_hold_busy", busy_l, 1'b0);
    im_work_en = 1'b1;
    idle(1);
    check1("resume_busy", busy_l, 1'b1);
    check1("resume_ready", ready_l, 1'b1);
    check1("resume_first_lsb", data_l, 1'b1);
    check1("resume_first_msb", data_m, 1'b0);
    shift_check(8'h55, 3);

    // Loopback against a receiver model: directed bytes then random bytes, random strobe gaps.
    tx = '{8'h00, 8'hFF, 8'h5A, 8'h96};
    for (int i = 0; i < 8; i++) tx.push_back(8'($urandom_range(0, 255)));
    exp_q  = tx;
    n_done = 0;
    nbits  = 0;
    cyc    = 0;
    rx_l   = 8'h00;
    rx_m   = 8'h00;
    gapc   = 2;
    write_byte(tx.pop_front());
    while (n_done < 12 && cyc < 20000) begin
      im_byte_valid = 1'b0;
      if (tx.size() > 0 && ready_l) begin
        im_byte       = tx[0];
        im_byte_valid = 1'b1;
      end
      pl = (gapc == 0);
      im_work_pluse = pl;
      if (pl) begin
        rx_l  = {data_l, rx_l[7:1]};
        rx_m  = {rx_m[6:0], data_m};
        nbits++;
        gapc  = int'($urandom_range(1, 4));
      end else begin
        gapc--;
      end
      idle(1);
      if (im_byte_valid) void'(tx.pop_front());
      im_byte_valid = 1'b0;
      im_work_pluse = 1'b0;
      if (pl) check1("lb_no_under", under_l, 1'b0);
      if (done_l) begin
        exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
        check8("lb_byte_lsb", rx_l, exp_b);
        check8("lb_byte_msb", rx_m, exp_b);
        check1("lb_done_msb", done_m, 1'b1);
        check8("lb_bits", 8'(nbits), 8'd8);
        nbits = 0;
        n_done++;
      end
      cyc++;
    end
    check8("lb_count", 8'(n_done), 8'd12);
    idle(2);

    // Reset mid-byte.
    write_byte(8'hF0);
    for (int i = 0; i < 4; i++) begin
      idle(3);
      strobe(dl, dm);
      check1("rstmid_lsb", dl, 1'b0);
      check1("rstmid_msb", dm, 1'b1);
    end
    write_byte(8'h3A);
    #2;
    rst_n = 1'b0;
    #1;
    check1("rstmid_busy", busy_l, 1'b0);
    check1("rstmid_ready", ready_l, 1'b1);
    check1("rstmid_data_lsb", data_l, IDLE_L);
    check1("rstmid_data_msb", data_m, IDLE_M);
    check1("rstmid_done", done_l, 1'b0);
    check1("rstmid_under", under_l, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    send_byte(8'hE1, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_8to1_transmit.md
Name: spi_8to1_transmit

Overview:
Parallel-to-serial byte transmitter for the SPI data layer, the counterpart of the layer-3 1-to-8 receiver. It accepts bytes over a valid/ready handshake into a one-entry holding buffer, then shifts them out one bit per im_work_pluse strobe from the timing layer. Bit order and im_work_en semantics match the receiver, so a transmitter and receiver driven by the same strobes form a bit-exact loopback.

Parameters:
IDLE_LEVEL, 1'b0, om_data level driven when no byte is being shifted.
MSB_FIRST, 0, 0 = bit 0 first (matches receiver); 1 = bit 7 first.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous reset, active-low
im_work_en  input  1  transfer window; low aborts current byte
im_work_pluse  input  1  one-cycle bit strobe; om_data is sampled by the peer in this cycle
im_byte  input  8  parallel byte to send
im_byte_valid  input  1  im_byte is valid
om_byte_ready  output  1  holding buffer can accept; a transfer occurs when valid&&ready
om_data  output  1  registered serial data bit
om_busy  output  1  a byte is loaded in the shift register
om_byte_done  output  1  one-cycle pulse: last bit of a byte consumed
om_underrun  output  1  one-cycle pulse: strobe arrived with nothing to send

Behaviour:
- Reset (async, rst_n low): shift reg 0, bit_cnt 0, buffer empty, state IDLE; om_data=IDLE_LEVEL, om_byte_ready=1, om_busy=0, om_byte_done=0, om_underrun=0.
- Storage: 8-bit shift reg plus 3-bit bit_cnt; 8-bit holding buffer with full flag. om_byte_ready = !buf_full (combinational from flag). Writes are accepted regardless of im_work_en.
- States: IDLE (shift reg empty, om_busy=0) and SHIFT (om_busy=1).
- Load rule: a load into the shift reg happens at an edge where (state IDLE) or (SHIFT && strobe && bit_cnt==7). The source is the buffer if full (buffer clears); otherwise im_byte if valid&&ready in that cycle (bypass: buffer stays empty). With no source, the block goes to or stays in IDLE.
- Latency: valid byte written in IDLE with empty buffer at edge N -> om_data = first bit, om_busy=1 from N+1.
- om_data register: on load = first bit (bit0, or bit7 if MSB_FIRST); on mid-byte strobe = next bit (bit_cnt+1 in bit order); on entering IDLE = IDLE_LEVEL. Stable between strobes.
- SHIFT with strobe: bit_cnt increments. At bit_cnt==7 it wraps to 0, om_byte_done=1 next cycle, and the load rule applies. The next byte is back-to-back with no idle strobe.
- Underrun: strobe while IDLE and im_work_en=1 -> om_underrun=1 next cycle. om_data stays IDLE_LEVEL and no byte_done is raised.
- Abort: im_work_en=0 (highest priority after reset): bit_cnt=0, shift reg discarded, state IDLE, om_data=IDLE_LEVEL. No byte_done. Holding buffer retained. Strobes are ignored while en=0. When en returns, a full buffer loads on the next edge.
- Simultaneous events:
  - A buffer write in the same cycle as a load from the buffer is accepted only if ready was already 1. Buffer full implies ready=0, so there is no collision.
  - Write and end-of-byte with an empty buffer take the bypass path.
- Reset mid-byte: immediate return to reset values; partial byte lost.

Test Plan:
- Single byte: write 0xA5 in IDLE, en=1, 8 strobes 4 cycles apart -> om_data at strobes = 1,0,1,0,0,1,0,1. om_byte_done one cycle after 8th strobe, then om_busy=0 and om_data=0.
- Back-to-back: write 0x3C then 0xC3 (second goes to buffer, om_byte_ready=0 until first byte ends) -> 16 strobes give 0,0,1,1,1,1,0,0,1,1,0,0,0,0,1,1 with no gap. Two byte_done pulses, 8 strobes apart.
- Underrun: en=1, no byte, 2 strobes -> two om_underrun pulses, om_data=IDLE_LEVEL. Then write 0x01 -> next strobe sees 1.
- Abort: write 0xFF, 3 strobes, drop en for 2 cycles with 0x55 in buffer -> om_data=0, no byte_done, 0x55 loads after en rises. The next 8 strobes give 1,0,1,0,1,0,1,0.
- Loopback: connect to 1-to-8 receiver with shared en/strobe, send 0x00, 0xFF, 0x5A, 0x96 -> receiver byte equals sent byte after each byte_done. Repeat with MSB_FIRST=1 against a reversed reference model.
- Reset mid-byte: assert rst_n low after 4 strobes of 0xF0 -> all outputs at reset values within the same cycle, and the next byte starts at bit 0.
